// File: rtl/router_fsm.sv
// Control FSM for a 1-input, 3-output packet router: decodes the header address,
// sequences payload/parity loading and stalls on full or busy output FIFOs.
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       lfd_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
  localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
  localparam logic [2:0] LOAD_DATA          = 3'd2;
  localparam logic [2:0] FIFO_FULL_STATE    = 3'd3;
  localparam logic [2:0] LOAD_AFTER_FULL    = 3'd4;
  localparam logic [2:0] LOAD_PARITY        = 3'd5;
  localparam logic [2:0] CHECK_PARITY_ERROR = 3'd6;
  localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd7;

  logic [2:0] state, next_state;
  logic [1:0] addr;
  logic       hdr_empty;
  logic       addr_empty;
  logic       soft_hit;

  always_ff @(posedge clock) begin
    if (resetn) state <= DECODE_ADDRESS;
    else        state <= next_state;
  end

  // Latch the header address so later stages don't depend on data_in holding it
  always_ff @(posedge clock) begin
    if (resetn)
      addr <= 2'd0;
    else if (state == DECODE_ADDRESS && pkt_valid)
      addr <= data_in;
  end

  always_comb begin
    hdr_empty = 1'b0;
    case (data_in)
      2'd0:    hdr_empty = fifo_empty_0;
      2'd1:    hdr_empty = fifo_empty_1;
      2'd2:    hdr_empty = fifo_empty_2;
      default: hdr_empty = 1'b0;
    endcase
  end

  always_comb begin
    addr_empty = 1'b0;
    soft_hit   = 1'b0;
    case (addr)
      2'd0:    begin addr_empty = fifo_empty_0; soft_hit = soft_reset_0; end
      2'd1:    begin addr_empty = fifo_empty_1; soft_hit = soft_reset_1; end
      2'd2:    begin addr_empty = fifo_empty_2; soft_hit = soft_reset_2; end
      default: begin addr_empty = 1'b0;         soft_hit = 1'b0;         end
    endcase
  end

  always_comb begin
    next_state = DECODE_ADDRESS;
    if (state != DECODE_ADDRESS && soft_hit) begin
      next_state = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS:
          if (pkt_valid && data_in != 2'd3)
            next_state = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          else
            next_state = DECODE_ADDRESS;
        LOAD_FIRST_DATA:
          next_state = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       next_state = FIFO_FULL_STATE;
          else if (!pkt_valid) next_state = LOAD_PARITY;
          else                 next_state = LOAD_DATA;
        FIFO_FULL_STATE:
          next_state = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)           next_state = DECODE_ADDRESS;
          else if (low_packet_valid) next_state = LOAD_PARITY;
          else                       next_state = LOAD_DATA;
        LOAD_PARITY:
          next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:
          next_state = addr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        default:
          next_state = DECODE_ADDRESS;
      endcase
    end
  end

  always_comb begin
    detect_add    = (state == DECODE_ADDRESS);
    lfd_state     = (state == LOAD_FIRST_DATA);
    ld_state      = (state == LOAD_DATA);
    laf_state     = (state == LOAD_AFTER_FULL);
    full_state    = (state == FIFO_FULL_STATE);
    rst_int_reg   = (state == CHECK_PARITY_ERROR);
    write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                    (state == LOAD_AFTER_FULL);
    busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks every transition with hand-derived Moore outputs.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_packet_valid;
  logic       write_enb_reg, detect_add, ld_state, laf_state;
  logic       lfd_state, full_state, rst_int_reg, busy;

  int checks   = 0;
  int failures = 0;

  // Output vector order: detect_add, lfd, ld, laf, full, rst_int, write_enb, busy
  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0010;
  localparam logic [7:0] O_LAF = 8'b0001_0011;
  localparam logic [7:0] O_FFS = 8'b0000_1001;
  localparam logic [7:0] O_LP  = 8'b0000_0011;
  localparam logic [7:0] O_CPE = 8'b0000_0101;
  localparam logic [7:0] O_WTE = 8'b0000_0001;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid), .write_enb_reg(write_enb_reg),
    .detect_add(detect_add), .ld_state(ld_state), .laf_state(laf_state),
    .lfd_state(lfd_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb_reg, busy};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // From DA: header for port 0 with empty FIFO, land in LD with pkt_valid still high
  task automatic to_ld(input string tag);
    pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
    step(); chk({tag, "_lfd"}, O_LFD);
    step(); chk({tag, "_ld"}, O_LD);
  endtask

  initial begin
    resetn = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_packet_valid = 1'b0;

    step(); resetn = 1'b0;
    chk("reset", O_DA);
    step(); chk("idle_da", O_DA);

    // Normal packet to port 0
    to_ld("norm");
    step(); chk("norm_ld_hold", O_LD);
    pkt_valid = 1'b0;
    step(); chk("norm_lp", O_LP);
    step(); chk("norm_cpe", O_CPE);
    step(); chk("norm_da", O_DA);

    // Full mid-packet, fifo_full and pkt_valid fall together, low_packet_valid=1
    to_ld("full1");
    fifo_full = 1'b1; pkt_valid = 1'b0;
    step(); chk("full1_ffs", O_FFS);
    step(); chk("full1_ffs_hold", O_FFS);
    fifo_full = 1'b0; low_packet_valid = 1'b1;
    step(); chk("full1_laf", O_LAF);
    step(); chk("full1_lp", O_LP);
    low_packet_valid = 1'b0;
    step(); chk("full1_cpe", O_CPE);
    step(); chk("full1_da", O_DA);

    // Full mid-packet, low_packet_valid=0: LAF returns to LD
    to_ld("full2");
    fifo_full = 1'b1;
    step(); chk("full2_ffs", O_FFS);
    fifo_full = 1'b0;
    step(); chk("full2_laf", O_LAF);
    step(); chk("full2_ld", O_LD);
    pkt_valid = 1'b0;
    step(); chk("full2_lp", O_LP);
    step(); chk("full2_cpe", O_CPE);
    step(); chk("full2_da", O_DA);

    // Full mid-packet, parity already latched: LAF returns to DA
    to_ld("full3");
    fifo_full = 1'b1; pkt_valid = 1'b0;
    step(); chk("full3_ffs", O_FFS);
    fifo_full = 1'b0; parity_done = 1'b1;
    step(); chk("full3_laf", O_LAF);
    step(); chk("full3_da", O_DA);
    parity_done = 1'b0;

    // Busy destination 2; WTE must follow the latched address, not data_in
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
    step(); chk("wte_1", O_WTE);
    data_in = 2'd0; fifo_empty_0 = 1'b1;
    step(); chk("wte_2", O_WTE);
    step(); chk("wte_3", O_WTE);
    fifo_empty_2 = 1'b1;
    step(); chk("wte_lfd", O_LFD);
    step(); chk("wte_ld", O_LD);
    pkt_valid = 1'b0;
    step(); chk("wte_lp", O_LP);
    step(); chk("wte_cpe", O_CPE);
    step(); chk("wte_da", O_DA);

    // Soft reset for port 1: other port's soft reset ignored, own one aborts
    pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b1;
    step(); chk("soft_lfd", O_LFD);
    step(); chk("soft_ld", O_LD);
    soft_reset_0 = 1'b1;
    step(); chk("soft_other", O_LD);
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b1;
    step(); chk("soft_own", O_DA);
    soft_reset_1 = 1'b0; pkt_valid = 1'b0;
    step(); chk("soft_idle", O_DA);

    // Invalid address 3 is ignored
    pkt_valid = 1'b1; data_in = 2'd3;
    step(); chk("inv_1", O_DA);
    step(); chk("inv_2", O_DA);
    pkt_valid = 1'b0;

    // CPE with a full FIFO goes to FFS
    to_ld("cpe");
    pkt_valid = 1'b0;
    step(); chk("cpe_lp", O_LP);
    fifo_full = 1'b1;
    step(); chk("cpe_cpe", O_CPE);
    step(); chk("cpe_ffs", O_FFS);
    fifo_full = 1'b0; parity_done = 1'b1;
    step(); chk("cpe_laf", O_LAF);
    step(); chk("cpe_da", O_DA);
    parity_done = 1'b0;

    // Reset mid-packet
    to_ld("rst");
    resetn = 1'b1;
    step(); chk("rst_mid", O_DA);
    resetn = 1'b0; pkt_valid = 1'b0;
    step(); chk("rst_after", O_DA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_fsm.md
Name:
router_fsm

Overview:
- Control state machine for a 1-input, 3-output packet router.
- Watches the incoming packet header address, payload valid, and the status of three output FIFOs.
- Drives Moore control strobes for the register and synchronizer blocks: address detect, first-data load, data load, load-after-full, parity check, write enable and busy.
- Sits between the router input register block and the FIFO/synchronizer blocks.

Parameters:
- None. State encoding is a local constant: 8 states, 3-bit binary.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- resetn  in  1  one clock; reset is synchronous and active-high. The port keeps the codebase name resetn but is asserted high.
- pkt_valid  in  1  packet byte valid from the source.
- data_in  in  2  destination address, taken from header bits [1:0].
- fifo_full  in  1  addressed FIFO is full.
- fifo_empty_0/1/2  in  1 each  output FIFO 0/1/2 is empty.
- soft_reset_0/1/2  in  1 each  timeout soft reset for FIFO 0/1/2.
- parity_done  in  1  parity byte has been latched by the register block.
- low_packet_valid  in  1  pkt_valid fell while the FIFO was full.
- write_enb_reg  out  1  write enable to the FIFO.
- detect_add  out  1  in DECODE_ADDRESS.
- ld_state  out  1  in LOAD_DATA.
- laf_state  out  1  in LOAD_AFTER_FULL.
- lfd_state  out  1  in LOAD_FIRST_DATA.
- full_state  out  1  in FIFO_FULL_STATE.
- rst_int_reg  out  1  in CHECK_PARITY_ERROR.
- busy  out  1  router cannot accept a new byte.

Behaviour:
- States: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE), WAIT_TILL_EMPTY (WTE).
- Reset:
  - resetn=1 at a rising edge puts the FSM in DA and clears the address register to 0.
  - Outputs after reset: detect_add=1, all other outputs 0.
- Address register: in DA with pkt_valid=1, data_in is captured into a 2-bit addr register. WTE and soft-reset checks use addr, not live data_in.
- Soft reset:
  - If soft_reset_N=1 with N == addr and state is not DA, next state is DA.
  - Soft reset has priority over every other transition except resetn.
- Transitions, evaluated on each rising edge:
  - DA → LFD: pkt_valid and data_in=N (N in 0..2) and fifo_empty_N=1.
  - DA → WTE: pkt_valid and data_in=N (N in 0..2) and fifo_empty_N=0.
  - DA stays in DA if pkt_valid=0 or data_in=3. Address 3 is invalid; the packet is ignored.
  - LFD → LD unconditionally.
  - LD → FFS if fifo_full=1; else LD → LP if pkt_valid=0; else stay in LD.
  - FFS → LAF when fifo_full=0; else stay in FFS.
  - LAF → DA if parity_done=1.
  - LAF → LP if parity_done=0 and low_packet_valid=1.
  - LAF → LD if parity_done=0 and low_packet_valid=0.
  - LP → CPE unconditionally.
  - CPE → FFS if fifo_full=1; else CPE → DA.
  - WTE → LFD when fifo_empty_addr=1; else stay in WTE.
- Outputs are Moore, decoded from the current state only:
  - detect_add = DA.
  - lfd_state = LFD.
  - ld_state = LD.
  - laf_state = LAF.
  - full_state = FFS.
  - rst_int_reg = CPE.
  - write_enb_reg = LD | LP | LAF.
  - busy = LFD | FFS | LAF | LP | CPE | WTE, i.e. 0 only in DA and LD.
- Exactly one state-decode output (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) is high at a time, or none when in LP or WTE.
- Simultaneous fifo_full and pkt_valid=0 in LD: fifo_full wins and the next state is FFS.
- X/unknown inputs need not be handled. The state register must never leave the 8 legal codes; an illegal code recovers to DA.

Test Plan:
- Reset:
  - Stimulus: resetn=1 for one edge, then resetn=0.
  - Required: detect_add=1, busy=0, write_enb_reg=0, all other outputs 0.
- Normal packet to port 0:
  - Stimulus: pkt_valid=1, data_in=0, fifo_empty_0=1 in DA; two edges later pkt_valid=0, fifo_full=0.
  - Required state sequence: DA→LFD (lfd_state=1, busy=1) → LD (ld_state=1, write_enb_reg=1, busy=0) → LP (write_enb_reg=1, busy=1) → CPE (rst_int_reg=1) → DA.
- FIFO full mid-packet:
  - Stimulus: from LD, fifo_full=1 for one cycle, then fifo_full=0, parity_done=0, low_packet_valid=1.
  - Required state sequence: FFS (full_state=1, busy=1) → LAF (laf_state=1, write_enb_reg=1) → LP → CPE → DA.
  - Repeat with low_packet_valid=0: LAF → LD.
  - Repeat with parity_done=1: LAF → DA.
- Busy destination:
  - Stimulus: pkt_valid=1, data_in=2, fifo_empty_2=0; after 3 cycles fifo_empty_2=1.
  - Required: WTE with busy=1 for 3 cycles, then LFD, then LD.
- Soft reset:
  - Stimulus: in LD for addr=1, pulse soft_reset_1=1.
  - Required: next state DA with detect_add=1.
  - Stimulus: soft_reset_0=1 instead.
  - Required: FSM stays in LD.
- Invalid address and CPE with full FIFO:
  - Stimulus: data_in=3 with pkt_valid=1.
  - Required: FSM stays in DA.
  - Stimulus: CPE with fifo_full=1.
  - Required: next state FFS.
